// File: rtl/regfile_writer.sv
// regfile_writer
// Write-side companion to the register file. Completed results are queued in a
// small circular FIFO (Q). They drain one per clock into a single output
// register (W), which drives the register file's write port. Lookup logic lets
// decode see values that are still queued and not yet committed.
//
// Ports:
//   clk, reset                  clock; synchronous active-low reset
//   in_valid/in_reg/in_data     result input
//   in_ready                    FIFO can accept (equals !full)
//   hold                        1 = do not pop the FIFO this cycle
//   writeReg/writeData          register file write index/data (registered)
//   writeEnable                 register file write strobe (registered)
//   lk1_reg/lk2_reg             bypass lookup indices
//   lk1_hit/lk2_hit             a pending write to that register exists
//   lk1_data/lk2_data           youngest pending value, 0 when no hit
//   pending                     per-register mask of queued or W-stage writes
//   count                       FIFO occupancy (the W stage is not counted)
//
// Handshake: an input is accepted on a rising edge where in_valid && in_ready.
// in_ready depends only on count. While in_ready is low the source must keep
// in_valid and its payload stable.
module regfile_writer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       hold,
  output logic [ADDR_W-1:0]          writeReg,
  output logic [DATA_W-1:0]          writeData,
  output logic                       writeEnable,
  input  logic [ADDR_W-1:0]          lk1_reg,
  input  logic [ADDR_W-1:0]          lk2_reg,
  output logic                       lk1_hit,
  output logic                       lk2_hit,
  output logic [DATA_W-1:0]          lk1_data,
  output logic [DATA_W-1:0]          lk2_data,
  output logic [(1<<ADDR_W)-1:0]     pending,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [ADDR_W-1:0] r_q_reg  [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_write_en;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [NREG-1:0]   w_pending;
  logic              w_lk1_hit;
  logic              w_lk2_hit;
  logic [DATA_W-1:0] w_lk1_data;
  logic [DATA_W-1:0] w_lk2_data;
  logic [PTR_W-1:0]  w_idx;

  // in_ready looks only at count. A pop on the same edge does not free a slot early.
  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_push = in_valid && !w_full;
  assign w_pop  = (r_count != '0) && !hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_write_en   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      if (w_push) begin
        r_q_reg[r_wr_ptr]  <= in_reg;
        r_q_data[r_wr_ptr] <= in_data;
        r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
      end
      // writeEnable comes straight from this flop. The register file gates
      // its clock with it, so it must never be combinational.
      if (w_pop) begin
        r_write_reg  <= r_q_reg[r_rd_ptr];
        r_write_data <= r_q_data[r_rd_ptr];
        r_write_en   <= 1'b1;
        r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_write_en   <= 1'b0;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Scan from oldest (W, then the Q head) to newest. A later match overwrites
  // an earlier one, so the youngest pending value wins.
  always_comb begin
    w_pending  = '0;
    w_lk1_hit  = 1'b0;
    w_lk2_hit  = 1'b0;
    w_lk1_data = '0;
    w_lk2_data = '0;
    w_idx      = '0;
    if (r_write_en) begin
      w_pending[r_write_reg] = 1'b1;
      if (lk1_reg == r_write_reg) begin
        w_lk1_hit  = 1'b1;
        w_lk1_data = r_write_data;
      end
      if (lk2_reg == r_write_reg) begin
        w_lk2_hit  = 1'b1;
        w_lk2_data = r_write_data;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        w_pending[r_q_reg[w_idx]] = 1'b1;
        if (lk1_reg == r_q_reg[w_idx]) begin
          w_lk1_hit  = 1'b1;
          w_lk1_data = r_q_data[w_idx];
        end
        if (lk2_reg == r_q_reg[w_idx]) begin
          w_lk2_hit  = 1'b1;
          w_lk2_data = r_q_data[w_idx];
        end
      end
    end
  end

  assign in_ready    = !w_full;
  assign writeReg    = r_write_reg;
  assign writeData   = r_write_data;
  assign writeEnable = r_write_en;
  assign count       = r_count;
  assign pending     = w_pending;
  assign lk1_hit     = w_lk1_hit;
  assign lk2_hit     = w_lk2_hit;
  assign lk1_data    = w_lk1_data;
  assign lk2_data    = w_lk2_data;

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer. Inputs are driven #1 after a rising edge.
// Outputs are checked at that same point, once they have settled.
module tb_regfile_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_reg;
  logic [31:0] in_data;
  logic        in_ready;
  logic        hold;
  logic [1:0]  writeReg;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [1:0]  lk1_reg;
  logic [1:0]  lk2_reg;
  logic        lk1_hit;
  logic        lk2_hit;
  logic [31:0] lk1_data;
  logic [31:0] lk2_data;
  logic [3:0]  pending;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  regfile_writer #(.DEPTH(4), .DATA_W(32), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_reg(in_reg),
    .in_data(in_data), .in_ready(in_ready), .hold(hold),
    .writeReg(writeReg), .writeData(writeData), .writeEnable(writeEnable),
    .lk1_reg(lk1_reg), .lk2_reg(lk2_reg), .lk1_hit(lk1_hit), .lk2_hit(lk2_hit),
    .lk1_data(lk1_data), .lk2_data(lk2_data), .pending(pending), .count(count)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [1:0] r, input logic [31:0] d);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
  endtask

  initial begin
    // reset with in_valid asserted: nothing may be captured
    reset = 1'b0; hold = 1'b0; lk1_reg = 2'd0; lk2_reg = 2'd0;
    drive_push(2'd3, 32'h55);
    step(); step();
    check("rst_we",      {31'd0, writeEnable}, 32'd0);
    check("rst_wreg",    {30'd0, writeReg},    32'd0);
    check("rst_wdata",   writeData,            32'd0);
    check("rst_ready",   {31'd0, in_ready},    32'd1);
    check("rst_count",   {29'd0, count},       32'd0);
    check("rst_pending", {28'd0, pending},     32'd0);
    check("rst_lk1hit",  {31'd0, lk1_hit},     32'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    step();

    // single write: accepted at edge N
    drive_push(2'd2, 32'hDEADBEEF);
    lk1_reg = 2'd2;
    step();
    in_valid = 1'b0;
    check("sw_q_count",   {29'd0, count},      32'd1);
    check("sw_q_we",      {31'd0, writeEnable}, 32'd0);
    check("sw_q_pending", {28'd0, pending},    32'h4);
    check("sw_q_lkhit",   {31'd0, lk1_hit},    32'd1);
    check("sw_q_lkdata",  lk1_data,            32'hDEADBEEF);
    step(); // N+1
    check("sw_w_we",      {31'd0, writeEnable}, 32'd1);
    check("sw_w_wreg",    {30'd0, writeReg},   32'd2);
    check("sw_w_wdata",   writeData,           32'hDEADBEEF);
    check("sw_w_pending", {28'd0, pending},    32'h4);
    check("sw_w_lkdata",  lk1_data,            32'hDEADBEEF);
    step(); // N+2
    check("sw_done_we",      {31'd0, writeEnable}, 32'd0);
    check("sw_done_pending", {28'd0, pending},     32'd0);
    check("sw_done_wreg",    {30'd0, writeReg},    32'd2);
    check("sw_done_lkhit",   {31'd0, lk1_hit},     32'd0);

    // fill and stall
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_push(2'(i), 32'h10 + 32'(i));
      exp_q.push_back(32'h10 + 32'(i));
      step();
    end
    check("fill_count",   {29'd0, count},       32'd4);
    check("fill_ready",   {31'd0, in_ready},    32'd0);
    check("fill_pending", {28'd0, pending},     32'hF);
    check("fill_we",      {31'd0, writeEnable}, 32'd0);
    drive_push(2'd0, 32'h99); // must be ignored
    step();
    in_valid = 1'b0;
    check("fill_ovf_count", {29'd0, count}, 32'd4);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = exp_q.pop_front();
      check("drain_we",    {31'd0, writeEnable}, 32'd1);
      check("drain_data",  writeData,            exp_v);
      check("drain_reg",   {30'd0, writeReg},    32'(i));
      check("drain_count", {29'd0, count},       32'(3 - i));
    end
    step();
    check("drain_end_we", {31'd0, writeEnable}, 32'd0);

    // youngest-wins bypass
    hold = 1'b1;
    drive_push(2'd1, 32'hAAAA0000); step();
    drive_push(2'd1, 32'hBBBB0000); step();
    in_valid = 1'b0;
    lk1_reg = 2'd1; lk2_reg = 2'd3;
    #1;
    check("byp_hit1",    {31'd0, lk1_hit},  32'd1);
    check("byp_data1",   lk1_data,          32'hBBBB0000);
    check("byp_hit2",    {31'd0, lk2_hit},  32'd0);
    check("byp_data2",   lk2_data,          32'd0);
    check("byp_pending", {28'd0, pending},  32'h2);
    hold = 1'b0;
    step();
    check("byp_w1_data",  writeData, 32'hAAAA0000);
    check("byp_w1_lk",    lk1_data,  32'hBBBB0000);
    step();
    check("byp_w2_data",  writeData, 32'hBBBB0000);
    check("byp_w2_lk",    lk1_data,  32'hBBBB0000);
    step();
    check("byp_end_hit",  {31'd0, lk1_hit}, 32'd0);

    // simultaneous push and pop over 8 entries, pointers wrap
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_push(2'(i), 32'h100 + 32'(i));
      exp_q.push_back(32'h100 + 32'(i));
      step();
    end
    check("sim_count3", {29'd0, count}, 32'd3);
    hold = 1'b0;
    for (int i = 3; i < 8; i++) begin
      drive_push(2'(i), 32'h100 + 32'(i));
      exp_q.push_back(32'h100 + 32'(i));
      step();
      exp_v = exp_q.pop_front();
      check("sim_count", {29'd0, count},       32'd3);
      check("sim_we",    {31'd0, writeEnable}, 32'd1);
      check("sim_data",  writeData,            exp_v);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = exp_q.pop_front();
      check("sim_tail_we",   {31'd0, writeEnable}, 32'd1);
      check("sim_tail_data", writeData,            exp_v);
    end
    step();
    check("sim_end_we",    {31'd0, writeEnable}, 32'd0);
    check("sim_end_count", {29'd0, count},       32'd0);

    // reset mid-drain
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_push(2'(i), 32'h200 + 32'(i));
      step();
    end
    in_valid = 1'b0;
    hold = 1'b0;
    step();
    check("mid_we",    {31'd0, writeEnable}, 32'd1);
    check("mid_data",  writeData,            32'h200);
    check("mid_count", {29'd0, count},       32'd3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_we",      {31'd0, writeEnable}, 32'd0);
    check("mid_rst_count",   {29'd0, count},       32'd0);
    check("mid_rst_data",    writeData,            32'd0);
    check("mid_rst_ready",   {31'd0, in_ready},    32'd1);
    check("mid_rst_pending", {28'd0, pending},     32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_after_we", {31'd0, writeEnable}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
